// File: rtl/tick_scheduler.sv
// tick_scheduler: four-channel programmable timebase.
// A free-running prescaler divides the clock down to a shared base tick
// (CLK_HZ/TICK_HZ clocks). Each channel counts base ticks up to its own
// programmable period and emits a one-cycle tick plus a toggling square wave.
//
// Ports:
//   clk100MHz   system clock, rising edge
//   rst_n       asynchronous active-low reset
//   cfg_we      period write strobe (no back-pressure)
//   cfg_ch      channel index for the write
//   cfg_period  new period in base ticks, 0 disables the channel
//   cfg_ack     registered cfg_we
//   run         per-channel level enable
//   base_tick   one-cycle pulse every CLK_HZ/TICK_HZ clocks
//   tick        per-channel one-cycle pulse
//   sq          per-channel square output, toggles on every tick
module tick_scheduler #(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned TICK_HZ = 1000,
   parameter int unsigned PW      = 16
) (
   input  logic          clk100MHz,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_ch,
   input  logic [PW-1:0] cfg_period,
   output logic          cfg_ack,
   input  logic [3:0]    run,
   output logic          base_tick,
   output logic [3:0]    tick,
   output logic [3:0]    sq
);

   // DIV must be an integer >= 2; the counter width follows from it.
   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned NCH = 4;

   localparam logic [CW-1:0] PRE_LAST   = CW'(DIV - 1);
   localparam logic [PW-1:0] PERIOD_RST = PW'(1000);

   logic [CW-1:0] pre_cnt;

   logic [PW-1:0] period_q [NCH];
   logic [PW-1:0] period_d [NCH];
   logic [PW-1:0] cnt_q    [NCH];
   logic [PW-1:0] cnt_d    [NCH];
   logic [NCH-1:0] tick_d;
   logic [NCH-1:0] sq_d;

   // Free-running prescaler, independent of run and configuration.
   always_ff @(posedge clk100MHz or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt   <= '0;
         base_tick <= 1'b0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt   <= '0;
         base_tick <= 1'b1;
      end else begin
         pre_cnt   <= pre_cnt + CW'(1);
         base_tick <= 1'b0;
      end
   end

   // Acknowledge is simply the write strobe delayed by one cycle.
   always_ff @(posedge clk100MHz or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ack <= 1'b0;
      end else begin
         cfg_ack <= cfg_we;
      end
   end

   // Per-channel next state: write > stopped > disabled > base tick > hold.
   always_comb begin
      tick_d = '0;
      sq_d   = sq;
      for (int i = 0; i < NCH; i++) begin
         period_d[i] = period_q[i];
         cnt_d[i]    = cnt_q[i];
         if (cfg_we && (cfg_ch == 2'(i))) begin
            // A write restarts the phase but leaves the square level alone.
            period_d[i] = cfg_period;
            cnt_d[i]    = '0;
         end else if (!run[i]) begin
            cnt_d[i] = '0;
            sq_d[i]  = 1'b0;
         end else if (period_q[i] == '0) begin
            cnt_d[i] = '0;
         end else if (base_tick) begin
            // period_q >= 1 here, so period_q - 1 cannot underflow.
            if (cnt_q[i] == period_q[i] - PW'(1)) begin
               cnt_d[i]  = '0;
               tick_d[i] = 1'b1;
               sq_d[i]   = ~sq[i];
            end else begin
               cnt_d[i] = cnt_q[i] + PW'(1);
            end
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk100MHz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            period_q[i] <= PERIOD_RST;
            cnt_q[i]    <= '0;
         end
         tick <= '0;
         sq   <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            period_q[i] <= period_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
         tick <= tick_d;
         sq   <= sq_d;
      end
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: table-driven and sequence checks of tick_scheduler,
// plus randomized stimulus compared every cycle against a reference model
// that counts base ticks since the last phase restart and ticks whenever
// that count is a multiple of the period.
module tb_tick_scheduler;

   localparam int unsigned CLK_HZ  = 1000;
   localparam int unsigned TICK_HZ = 100;
   localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
   localparam int unsigned PW      = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_ch = 2'd0;
   logic [PW-1:0] cfg_period = '0;
   logic          cfg_ack;
   logic [3:0]    run = 4'd0;
   logic          base_tick;
   logic [3:0]    tick;
   logic [3:0]    sq;

   int n_checks = 0;
   int n_errors = 0;
   bit mdl_on = 1'b0;

   tick_scheduler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .PW(PW)) dut (
      .clk100MHz (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_period(cfg_period),
      .cfg_ack   (cfg_ack),
      .run       (run),
      .base_tick (base_tick),
      .tick      (tick),
      .sq        (sq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned mk;
   logic        m_base, m_ack;
   logic [3:0]  m_tick, m_sq;
   int unsigned m_n [4];
   int unsigned m_p [4];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mk     <= 0;
         m_base <= 1'b0;
         m_ack  <= 1'b0;
         m_tick <= '0;
         m_sq   <= '0;
         for (int i = 0; i < 4; i++) begin
            m_n[i] <= 0;
            m_p[i] <= 1000;
         end
      end else begin
         mk     <= mk + 1;
         m_base <= ((mk + 1) % DIV) == 0;
         m_ack  <= cfg_we;
         for (int i = 0; i < 4; i++) begin
            if (cfg_we && int'(cfg_ch) == i) begin
               m_p[i]    <= int'(cfg_period);
               m_n[i]    <= 0;
               m_tick[i] <= 1'b0;
            end else if (!run[i]) begin
               m_n[i]    <= 0;
               m_sq[i]   <= 1'b0;
               m_tick[i] <= 1'b0;
            end else if (m_p[i] == 0) begin
               m_n[i]    <= 0;
               m_tick[i] <= 1'b0;
            end else if (m_base) begin
               m_n[i] <= m_n[i] + 1;
               if (((m_n[i] + 1) % m_p[i]) == 0) begin
                  m_tick[i] <= 1'b1;
                  m_sq[i]   <= ~m_sq[i];
               end else begin
                  m_tick[i] <= 1'b0;
               end
            end else begin
               m_tick[i] <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mdl_on)
         check("model", int'({base_tick, cfg_ack, tick, sq}),
               int'({m_base, m_ack, m_tick, m_sq}));
   end

   // ---------------- helpers ----------------
   task automatic do_reset(input logic [3:0] r);
      @(negedge clk);
      rst_n  = 1'b0;
      cfg_we = 1'b0;
      run    = r;
      repeat (2) @(negedge clk);
      check("reset_state", int'({base_tick, cfg_ack, tick, sq}), 0);
      rst_n = 1'b1;
   endtask

   // Write lands on the next rising edge; returns at the negedge after it.
   task automatic write_cfg(input int ch, input int p);
      cfg_we     = 1'b1;
      cfg_ch     = 2'(ch);
      cfg_period = PW'(p);
      @(negedge clk);
      cfg_we = 1'b0;
      check("ack_high", int'(cfg_ack), 1);
      check("no_tick_on_write", int'(tick[ch]), 0);
   endtask

   task automatic wait_tick(input int ch, input int maxe, output int e);
      int n;
      e = -1;
      n = 0;
      while (e < 0 && n < maxe) begin
         @(negedge clk);
         n++;
         if (tick[ch]) e = n;
      end
   endtask

   task automatic wait_base(input int maxe, output int e);
      int n;
      e = -1;
      n = 0;
      while (e < 0 && n < maxe) begin
         @(negedge clk);
         n++;
         if (base_tick) e = n;
      end
   endtask

   typedef struct {
      int         ch;
      int         period;
      logic [3:0] run;
      int         first;  // edges from write to first tick, -1 = none
      int         next;   // edges between first and second tick
      logic       sq1;
      logic       sq2;
   } vec_t;

   vec_t vec [6];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
      $fatal(1);
   end

   initial begin
      int e, cnt, nb;
      logic prev;

      vec[0] = '{1, 3, 4'b0010, 30, 30, 1'b1, 1'b0};
      vec[1] = '{2, 1, 4'b0100, 10, 10, 1'b1, 1'b0};
      vec[2] = '{3, 5, 4'b1000, 50, 50, 1'b1, 1'b0};
      vec[3] = '{0, 2, 4'b0001, 20, 20, 1'b1, 1'b0};
      vec[4] = '{2, 0, 4'b0100, -1, -1, 1'b0, 1'b0};
      vec[5] = '{1, 3, 4'b0000, -1, -1, 1'b0, 1'b0};

      // Default period, channel 0 only.
      do_reset(4'b0001);
      mdl_on = 1'b1;
      wait_base(50, e);
      check("first_base_tick", e, 10);
      wait_tick(0, 10100, e);
      check("default_tick1", e, 10001 - 10);
      check("default_sq1", int'(sq[0]), 1);
      wait_tick(0, 10100, e);
      check("default_tick2", e, 10000);
      check("default_sq2", int'(sq[0]), 0);
      check("other_ticks", int'(tick[3:1]), 0);

      // Table of period writes issued on the first edge after reset.
      for (int t = 0; t < 6; t++) begin
         do_reset(vec[t].run);
         write_cfg(vec[t].ch, vec[t].period);
         @(negedge clk);
         check("ack_drop", int'(cfg_ack), 0);
         wait_tick(vec[t].ch, 600, e);
         check("vec_first", (e < 0) ? -1 : e + 1, vec[t].first);
         check("vec_sq1", int'(sq[vec[t].ch]), int'(vec[t].sq1));
         wait_tick(vec[t].ch, 600, e);
         check("vec_next", e, vec[t].next);
         check("vec_sq2", int'(sq[vec[t].ch]), int'(vec[t].sq2));
      end

      // Period 0 keeps a running channel silent; period 1 follows base_tick.
      do_reset(4'b0100);
      write_cfg(2, 0);
      cnt = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tick[2] || sq[2]) cnt++;
      end
      check("period0_silent", cnt, 0);
      write_cfg(2, 1);
      prev = base_tick;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         check("period1_follow", int'(tick[2]), int'(prev));
         prev = base_tick;
      end

      // Write on the same edge as base_tick: write wins, phase restarts.
      do_reset(4'b0001);
      write_cfg(0, 1);
      wait_base(50, e);
      check("base_seen", int'(base_tick), 1);
      write_cfg(0, 2);
      wait_tick(0, 100, e);
      check("write_on_base_next", e, 20);

      // Drop run mid-period, then resume.
      do_reset(4'b0010);
      write_cfg(1, 3);
      wait_tick(1, 100, e);
      check("run_first", e, 30);
      repeat (12) @(negedge clk);
      run[1] = 1'b0;
      cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (tick[1] || sq[1]) cnt++;
      end
      check("run_low_quiet", cnt, 0);
      run[1] = 1'b1;
      nb = base_tick ? 1 : 0;
      e = 0;
      while (!tick[1] && e < 100) begin
         @(negedge clk);
         e++;
         if (!tick[1] && base_tick) nb++;
      end
      check("resume_tick_seen", int'(tick[1]), 1);
      check("resume_base_count", nb, 3);
      check("resume_sq", int'(sq[1]), 1);

      // Asynchronous reset pulse mid-cycle.
      #1 rst_n = 1'b0;
      #1 check("async_reset", int'({base_tick, cfg_ack, tick, sq}), 0);
      #2 rst_n = 1'b1;
      wait_base(50, e);
      check("post_reset_base", e, 10);
      wait_tick(1, 10100, e);
      check("post_reset_period", e, 10001 - 10);

      // Randomized traffic against the model.
      do_reset(4'b1111);
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) begin
            cfg_we     = 1'b1;
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = PW'($urandom_range(0, 4));
         end else begin
            cfg_we = 1'b0;
         end
         if ($urandom_range(0, 31) == 0)
            run = run ^ 4'(1 << $urandom_range(0, 3));
      end
      @(negedge clk);
      cfg_we = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Four-channel programmable timebase controller for the lab board's 100 MHz clock domain. One free-running prescaler generates a 1 ms base tick that is shared among four independent channels. Each channel has a run-time programmable period in milliseconds and produces a single-cycle enable pulse plus a toggling square output. Sequential logic such as counters, displays and FSMs uses these outputs as clock enables instead of deriving new clocks.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 1000: base tick rate. DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- `PW`, default 16: period register width.
- `clk100MHz`  in  1  system clock. Single clock domain; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  period write strobe, sampled on each rising edge.
- `cfg_ch`  in  2  channel index for the write.
- `cfg_period`  in  PW  new period in base ticks; 0 disables the channel.
- `cfg_ack`  out  1  one-cycle acknowledge, asserted the cycle after an accepted write.
- `run`  in  4  per-channel enable, level-sensitive.
- `base_tick`  out  1  one-cycle pulse every DIV clocks.
- `tick`  out  4  per-channel one-cycle pulse.
- `sq`  out  4  per-channel square output; toggles on every tick.

## Operation
- Reset values, applied asynchronously while `rst_n` = 0:
  - prescaler count = 0, `base_tick` = 0
  - all channel counters = 0, all periods = 1000 (1 Hz at the default parameters)
  - `tick` = 0, `sq` = 0, `cfg_ack` = 0
- Prescaler:
  - The counter is ceil(log2(DIV)) bits and runs freely, independent of `run` and `cfg_we`.
  - On an edge where count = DIV-1: count returns to 0 and the registered `base_tick` is set to 1. On every other edge, `base_tick` is 0.
- Channel i, evaluated on each edge in priority order:
  1. Write hit (`cfg_we` = 1 and `cfg_ch` = i): period[i] ← `cfg_period`, counter[i] ← 0, no tick. The write wins even if `base_tick` = 1 on the same edge.
  2. `run[i]` = 0: counter[i] ← 0, `sq[i]` ← 0, `tick[i]` ← 0.
  3. period[i] = 0: counter[i] held at 0, no tick.
  4. `base_tick` = 1:
     - if counter[i] = period[i]-1: counter[i] ← 0, `tick[i]` ← 1, `sq[i]` toggles
     - otherwise counter[i] increments
  5. Otherwise: counter[i] holds and `tick[i]` ← 0.
- Arithmetic: counters are PW bits. A comparison against period-1 is valid only when period ≥ 1 (guaranteed by rule 3). Counters never wrap past period-1.
- Config handshake:
  - There is no back-pressure; a write is accepted on every cycle `cfg_we` = 1.
  - `cfg_ack` is the registered `cfg_we`. Back-to-back writes produce back-to-back acks.
  - A write to a running channel restarts its phase. `sq[i]` keeps its current level.
- Channels are fully independent. Multiple channels may assert `tick` on the same edge.

## Timing
- Number rising edges after `rst_n` deasserts starting at k = 1.
- `base_tick` is high after edges k = m·DIV for m ≥ 1.
- With `run[i]` held at 1 from reset and period P ≥ 1, `tick[i]` is high for exactly one cycle after edges k = m·P·DIV + 1.
- Tick rate = TICK_HZ/P. `sq` frequency = TICK_HZ/(2P).
- Write latency: `cfg_ack` and the new period are visible 1 cycle after the write edge. The first tick after a write arrives P full base ticks later.
- `run[i]` rising: counting starts on the next `base_tick`, so the first tick comes after P base ticks.
- `run[i]` falling: outputs are cleared on the next edge.
- Reset asserted mid-operation: every register is cleared immediately, with no clock required. The prescaler phase restarts from 0.

## Test plan
Bench parameters: CLK_HZ = 1000, TICK_HZ = 100, so DIV = 10.
1. Reset, then `run` = 4'b0001 with the default period 1000 → `base_tick` at k = 10, 20, …; `tick[0]` at k = 10001 and 20001; `sq[0]` toggles 0→1→0 at those edges; `tick[3:1]` stays 0.
2. Write ch1 period = 3, `run` = 4'b0010 → `cfg_ack` high for 1 cycle after the write; `tick[1]` every 30 cycles; `sq[1]` period 60 cycles.
3. Write ch2 period = 0 with `run[2]` = 1 → `tick[2]` and `sq[2]` stay 0 for 1000 cycles. Then write period = 1 → `tick[2]` follows every `base_tick` by one edge.
4. Write ch0 period = 2 on the same edge that `base_tick` = 1 → no tick on that edge; counter restarts; next `tick[0]` arrives 2 base ticks later (20 cycles).
5. Drop `run[1]` for 15 cycles mid-period, then raise it → `tick[1]` = 0 and `sq[1]` = 0 while low; the next tick comes 3 base ticks after counting resumes.
6. Pulse `rst_n` low for 3 ns mid-count, asynchronous to the clock → all outputs are 0 immediately; periods read back as 1000; `base_tick` next appears at k = 10.
